iq_credit_scheduler: RTL

- Assigns each renamed integer uop to one of NUM_IQ integer issue queues in the rename stage.
- Keeps one free-entry credit counter per IQ, so IQ overflow is prevented at rename rather than by IQ back-pressure.
- Distributes uops round-robin across IQs that have credit.
- Drives a stall into rename's stall OR, and a per-slot port index that rename registers alongside the uop.

---
 rtl/iq_credit_scheduler.sv | 95 +++++++++
 1 files changed

// File: rtl/iq_credit_scheduler.sv
// iq_credit_scheduler: rename-stage round-robin integer IQ assignment with per-IQ free-entry credits (ports: clk/rst, per-slot uop valid/isInt, fire, per-IQ freed counts, flush with post-flush free counts; outputs stall, per-slot port valid/index, credits, overflow pulse)
module iq_credit_scheduler #(
  parameter int WIDTH_ISSUE = 4,
  parameter int NUM_IQ = 2,
  parameter int IQ_DEPTH = 8,
  localparam int CW = $clog2(IQ_DEPTH + 1),
  localparam int FW = $clog2(WIDTH_ISSUE + 1),
  localparam int PW = $clog2(NUM_IQ)
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH_ISSUE-1:0] IN_uopValid,
  input  logic [WIDTH_ISSUE-1:0] IN_uopIsInt,
  input  logic IN_fire,
  input  logic [NUM_IQ-1:0][FW-1:0] IN_iqFreed,
  input  logic IN_flush,
  input  logic [NUM_IQ-1:0][CW-1:0] IN_flushFree,
  output logic OUT_stall,
  output logic [WIDTH_ISSUE-1:0] OUT_portValid,
  output logic [WIDTH_ISSUE-1:0][PW-1:0] OUT_port,
  output logic [NUM_IQ-1:0][CW-1:0] OUT_credits,
  output logic OUT_overflow
);
  localparam int NW = CW + 1;
  logic [NUM_IQ-1:0][CW-1:0] credit, tmp;
  logic [NUM_IQ-1:0][FW-1:0] placed;
  logic [NUM_IQ-1:0][NW-1:0] sum;
  logic [WIDTH_ISSUE-1:0][PW-1:0] port_raw;
  logic [WIDTH_ISSUE-1:0] valid_raw;
  logic [PW-1:0] rr_ptr, cur, sel, q;
  logic stall_raw, found, eff, ov_next;
  always_comb begin
    tmp = credit;
    cur = rr_ptr;
    placed = '0;
    stall_raw = 1'b0;
    valid_raw = '0;
    port_raw = '0;
    found = 1'b0;
    sel = '0;
    q = '0;
    for (int s = 0; s < WIDTH_ISSUE; s++) begin
      if (IN_uopValid[s] && IN_uopIsInt[s]) begin
        found = 1'b0;
        sel = cur;
        for (int k = 0; k < NUM_IQ; k++) begin
          q = cur + PW'(k);
          if (!found && tmp[q] != '0) begin
            found = 1'b1;
            sel = q;
          end
        end
        if (found) begin
          tmp[sel] = tmp[sel] - CW'(1);
          placed[sel] = placed[sel] + FW'(1);
          cur = sel + PW'(1);
          port_raw[s] = sel;
          valid_raw[s] = 1'b1;
        end else begin
          stall_raw = 1'b1;
        end
      end
    end
  end
  // Stall is independent of IN_fire so rename's stall OR cannot loop back through fire.
  assign eff = IN_fire && !stall_raw;
  always_comb begin
    sum = '0;
    ov_next = 1'b0;
    for (int i = 0; i < NUM_IQ; i++) begin
      sum[i] = {1'b0, credit[i]} - (eff ? NW'(placed[i]) : NW'(0)) + NW'(IN_iqFreed[i]);
      ov_next = ov_next | (sum[i] > NW'(IQ_DEPTH));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IQ; i++) credit[i] <= CW'(IQ_DEPTH);
      rr_ptr <= '0;
      OUT_overflow <= 1'b0;
    end else if (IN_flush) begin
      credit <= IN_flushFree;
      rr_ptr <= '0;
      OUT_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IQ; i++)
        credit[i] <= sum[i] > NW'(IQ_DEPTH) ? CW'(IQ_DEPTH) : sum[i][CW-1:0];
      OUT_overflow <= ov_next;
      if (eff && |valid_raw) rr_ptr <= cur;
    end
  end
  assign OUT_stall = !rst && stall_raw;
  assign OUT_portValid = (rst || stall_raw) ? '0 : valid_raw;
  assign OUT_port = port_raw;
  assign OUT_credits = credit;
endmodule
